// File: rtl/audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// audio_i2s_tx
//
// Stereo audio serializer for a codec DAC port. A divider on clk produces
// bclk, and a bit counter running on bclk falling edges produces lrck and
// dacdat. Sample pairs arrive through a valid/ready handshake into a
// one-entry holding buffer. The buffer is copied into the shift registers
// at each frame boundary.
//
// Handshake: a pair (s_left, s_right) is transferred on every clk edge where
// s_valid && s_ready. s_ready is high exactly when the holding buffer is
// empty. The source may present data at any time, and the data is ignored
// while s_ready is low.
//
// Optional build macro: UNDERFLOW_CNT_EN adds the underflow_count output,
// a saturating 16-bit count of underflow pulses.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   enable          1 = run serializer, 0 = outputs idle (synchronous)
//   s_valid/s_ready sample pair handshake
//   s_left/s_right  two's complement samples, SAMPLE_W bits each
//   bclk            bit clock, period 2*BCLK_DIV clk
//   lrck            0 = left slot, 1 = right slot
//   dacdat          serial data, MSB first, changes as bclk falls
//   frame_start     one-clk pulse when a frame is loaded
//   underflow       one-clk pulse when a frame loads with an empty buffer
//   underflow_count saturating underflow count (UNDERFLOW_CNT_EN only)
// ---------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4,
    parameter int MODE_I2S  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                bclk,
    output logic                lrck,
    output logic                dacdat,
    output logic                frame_start,
    output logic                underflow
`ifdef UNDERFLOW_CNT_EN
    ,
    output logic [15:0]         underflow_count
`endif
);

    localparam int              B_W    = $clog2(2 * SLOT_BITS);
    localparam logic [B_W-1:0]  B_LAST = B_W'(2 * SLOT_BITS - 1);
    localparam logic [B_W-1:0]  SLOT_B = B_W'(SLOT_BITS);
    localparam int              DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                bclk_q, bclk_d;
    logic [B_W-1:0]      b_q, b_d;
    logic                lrck_q, lrck_d;
    logic                dacdat_q, dacdat_d;
    logic                frame_start_q, frame_start_d;
    logic                underflow_q, underflow_d;
    logic                buf_full_q, buf_full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d;
    logic [SAMPLE_W-1:0] buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] sh_l_q, sh_l_d;
    logic [SAMPLE_W-1:0] sh_r_q, sh_r_d;

    // Scratch values for the falling-edge step
    logic [B_W-1:0]      b_nx;
    logic                lr_nx;
    logic [B_W-1:0]      pos;
    int                  d_idx;
    logic [SAMPLE_W-1:0] cur;
    logic [SAMPLE_W-1:0] cur_shift;

    always_comb begin
        div_cnt_d     = div_cnt_q;
        bclk_d        = bclk_q;
        b_d           = b_q;
        lrck_d        = lrck_q;
        dacdat_d      = dacdat_q;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;
        buf_full_d    = buf_full_q;
        buf_l_d       = buf_l_q;
        buf_r_d       = buf_r_q;
        sh_l_d        = sh_l_q;
        sh_r_d        = sh_r_q;

        b_nx      = (b_q == B_LAST) ? '0 : b_q + 1'b1;
        lr_nx     = (b_nx >= SLOT_B);
        pos       = lr_nx ? (b_nx - SLOT_B) : b_nx;
        d_idx     = int'(pos) - MODE_I2S;
        cur       = '0;
        cur_shift = '0;

        // Handshake runs regardless of enable so a pair can be queued early
        if (s_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_l_d    = s_left;
            buf_r_d    = s_right;
        end

        if (!enable) begin
            // b parks on the last index so the first falling step loads a frame
            div_cnt_d = '0;
            bclk_d    = 1'b0;
            lrck_d    = 1'b0;
            dacdat_d  = 1'b0;
            b_d       = B_LAST;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            if (bclk_q) begin
                b_d = b_nx;
                if (b_nx == '0) begin
                    frame_start_d = 1'b1;
                    if (buf_full_q) begin
                        sh_l_d     = buf_l_q;
                        sh_r_d     = buf_r_q;
                        buf_full_d = 1'b0;
                    end else begin
                        // No bypass: a pair accepted on this same edge stays
                        // in the buffer for the next frame.
                        sh_l_d      = '0;
                        sh_r_d      = '0;
                        underflow_d = 1'b1;
                    end
                end
                lrck_d = lr_nx;
                cur    = lr_nx ? sh_r_d : sh_l_d;
                if (d_idx >= 0 && d_idx < SAMPLE_W) begin
                    cur_shift = cur << d_idx;
                    dacdat_d  = cur_shift[SAMPLE_W-1];
                end else begin
                    dacdat_d = 1'b0;
                end
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            b_q           <= B_LAST;
            lrck_q        <= 1'b0;
            dacdat_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            buf_full_q    <= 1'b0;
            buf_l_q       <= '0;
            buf_r_q       <= '0;
            sh_l_q        <= '0;
            sh_r_q        <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            b_q           <= b_d;
            lrck_q        <= lrck_d;
            dacdat_q      <= dacdat_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            buf_full_q    <= buf_full_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
            sh_l_q        <= sh_l_d;
            sh_r_q        <= sh_r_d;
        end
    end

    assign s_ready     = ~buf_full_q;
    assign bclk        = bclk_q;
    assign lrck        = lrck_q;
    assign dacdat      = dacdat_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

`ifdef UNDERFLOW_CNT_EN
    logic [15:0] underflow_count_q, underflow_count_d;

    // Counts on the same edge that raises the underflow pulse
    always_comb begin
        underflow_count_d = underflow_count_q;
        if (underflow_d && (underflow_count_q != 16'hFFFF)) begin
            underflow_count_d = underflow_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_count_q <= '0;
        end else begin
            underflow_count_q <= underflow_count_d;
        end
    end

    assign underflow_count = underflow_count_q;
`endif

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
Parametrised stereo audio serializer driving the codec DAC port (bclk, lrck, dacdat) from a system clock.
- Generates bclk by integer division of clk and lrck per frame.
- Accepts stereo samples through a valid/ready handshake into a one-entry holding buffer.
- Serializes MSB-first in I2S or left-justified format.
- Replaces the fixed 16-bit, free-running, handshake-less sample pump.

Parameters:
SAMPLE_W, 16, bits per channel sample (8..32)
SLOT_BITS, 32, bclk periods per channel slot; must be >= SAMPLE_W + MODE_I2S
BCLK_DIV, 4, clk cycles per bclk half-period (>= 1)
MODE_I2S, 1, 1 = I2S (MSB one bclk after lrck edge), 0 = left-justified (MSB on lrck edge)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = run serializer; 0 = hold outputs idle
s_valid  input  1  sample pair valid
s_ready  output  1  holding buffer empty, pair accepted when s_valid && s_ready
s_left  input  SAMPLE_W  left sample, two's complement
s_right  input  SAMPLE_W  right sample, two's complement
bclk  output  1  bit clock to codec
lrck  output  1  frame clock: 0 = left slot, 1 = right slot
dacdat  output  1  serial data, changes on bclk falling edge
frame_start  output  1  one-clk pulse when a new frame is loaded
underflow  output  1  one-clk pulse when a frame starts with an empty buffer

Behaviour:
- Reset values: bclk=0, lrck=0, dacdat=0, frame_start=0, underflow=0. Buffer empty, so s_ready=1 once reset deasserts. Shift data cleared; div_cnt=0; bit counter b=last index.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 while enable=1.
  - At terminal count, bclk toggles and div_cnt wraps.
  - bclk period = 2*BCLK_DIV clk.
- Falling-edge step (clk edge where bclk goes 1->0):
  - b advances mod 2*SLOT_BITS.
  - lrck, dacdat and frame_start update registered on that same clk edge.
  - All outputs are registered; no combinational path from inputs to bclk/lrck/dacdat.
- Bit mapping:
  - lrck = (b >= SLOT_BITS); p = b mod SLOT_BITS; d = p - MODE_I2S.
  - dacdat = channel_sample[SAMPLE_W-1-d] when 0 <= d < SAMPLE_W, else 0.
  - Padding bits are 0.
- Frame load (b wraps to 0):
  - Buffer full: copy left/right into the shift registers, mark the buffer empty, pulse frame_start. s_ready=1 from the next clk.
  - Buffer empty: load zeros for both channels, pulse frame_start and underflow together.
- First frame after enable rises: the first falling step yields b=0, i.e. a frame load.
- Handshake:
  - Accept on s_valid && s_ready; the buffer captures both samples and s_ready drops next clk.
  - Inputs are ignored when s_ready=0.
  - No bypass: if accept and an empty-buffer frame load coincide, underflow is flagged, zeros are sent, and the accepted pair plays next frame.
- enable=0:
  - Synchronous, takes effect next clk, mid-frame abort allowed.
  - div_cnt=0, bclk=lrck=dacdat=0, b=last index; no frame_start or underflow pulses.
  - The buffer and handshake keep working (a pair may be queued before enable).
- Reset mid-frame: all state returns to reset values immediately and any buffered sample is discarded.

Optional Feature:
UNDERFLOW_CNT_EN
- Defined: adds output underflow_count [15:0].
  - Reset 0; increments on each underflow pulse.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; unaffected by enable.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bench configuration: SAMPLE_W=16, SLOT_BITS=32, BCLK_DIV=2, MODE_I2S=1 unless stated.
- Reset: assert reset_n=0 mid-frame -> all outputs 0 within the same clk; s_ready=1 after release.
- Basic I2S: queue L=16'hA5C3, R=16'h8001, enable=1 -> bclk period 4 clk. lrck low for 32 bclk then high. Left slot bits: 0, then A5C3 MSB-first, then 15 zeros. Right slot: 0, then 8001, then zeros. frame_start once per 64 bclk.
- Left-justified (MODE_I2S=0): same samples -> MSB on the same falling edge as the lrck transition; bit 16 of each slot is 0.
- Underflow: enable with empty buffer -> first frame all zeros, underflow and frame_start pulse on the same clk. Supply a pair on the exact load clk -> underflow still flagged, and the pair plays in the following frame.
- Back-pressure: hold s_valid=1 with 3 distinct pairs -> exactly one accept per frame, s_ready low between loads, output order preserved, no underflow.
- UNDERFLOW_CNT_EN build: 5 frames with no samples -> underflow_count=5. Force 65540 underflows -> count stays 16'hFFFF.
